// File: rtl/turbo_pkg.sv
// Shared constants and types for the turbo block encoder: RSC generator taps, FSM states, tail length.
// No logic, so no latency; backpressure does not apply to a package.
// Generator bit i is the coefficient of D^i.
package turbo_pkg;
  localparam logic [3:0] G_FB     = 4'b1101;  // 1 + D^2 + D^3
  localparam logic [3:0] G_FF     = 4'b1011;  // 1 + D + D^3
  localparam int         TAIL_LEN = 3;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ENC  = 2'd1,
    ST_TAIL = 2'd2
  } state_t;
endpackage

// File: rtl/rsc_encoder.sv
// One recursive systematic convolutional step (3-bit memory); parity is combinational from state and input.
// Latency: the state register updates on the clock after enable; parity/sys_bit have zero latency.
// Backpressure: the state advances only when enable is high and holds otherwise.
module rsc_encoder
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tail,
  input  logic u,
  output logic sys_bit,
  output logic parity
);

  logic [2:0] s;  // s[0]=s1 (newest), s[2]=s3
  logic       fb;
  logic       a;

  always_comb begin
    fb      = (G_FB[1] & s[0]) ^ (G_FB[2] & s[1]) ^ (G_FB[3] & s[2]);
    // In tail mode the input cancels the feedback, driving zeros into the register.
    sys_bit = tail ? fb : u;
    a       = sys_bit ^ fb;
    parity  = (G_FF[0] & a) ^ (G_FF[1] & s[0]) ^ (G_FF[2] & s[1]) ^ (G_FF[3] & s[2]);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      s <= 3'b000;
    end else if (enable) begin
      s <= {s[1], s[0], a};
    end
  end

endmodule

// File: rtl/turbo_block_encoder.sv
// Turbo block encoder: buffers BLK_LEN bits, emits {sys, p1, p2} per bit via two RSCs (TURBO_TAIL_EN adds 3 tail symbols).
// Latency: first symbol registered one cycle after the last input bit is accepted.
// Backpressure: symbols advance only on out_valid & out_ready; in_ready is low while a block is being emitted.
module turbo_block_encoder
  import turbo_pkg::*;
#(
  parameter int BLK_LEN = 16,
  parameter int INTLV_A = 5,
  parameter int INTLV_B = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sys,
  output logic out_p1,
  output logic out_p2,
  output logic out_last,
  output logic busy
);

  localparam int IDX_W = $clog2(BLK_LEN);
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(BLK_LEN - 1);
  localparam idx_t A_M      = idx_t'(INTLV_A);
  localparam idx_t B_M      = idx_t'(INTLV_B);
  localparam idx_t ONE      = idx_t'(1);

  state_t             state;
  logic [BLK_LEN-1:0] blk_buf;
  logic [BLK_LEN-1:0] buf_byp;
  logic [BLK_LEN-1:0] buf_src;
  idx_t               count;
  idx_t               k;
  idx_t               pi_k;
  idx_t               sel_k;
  idx_t               sel_pi;
  logic               accept;
  logic               last_in;
  logic               fire;
  logic               load;
  logic               load_tail;
  logic               next_last;
  logic               u1;
  logic               u2;
  logic               sys1;
  logic               p1;
  logic               p2;
  logic               unused_sys2;

`ifdef TURBO_TAIL_EN
  localparam logic [1:0] TAIL_LAST = 2'(TAIL_LEN - 1);
  logic [1:0] tail_cnt;
`endif

  always_comb begin
    accept  = (state == ST_LOAD) && in_valid;
    last_in = accept && (count == LAST_IDX);
    fire    = out_valid && out_ready;
    load    = last_in || (fire && !out_last);

    // Symbol 0 is formed while the last bit is still being written, so bypass it in.
    buf_byp        = blk_buf;
    buf_byp[count] = in_data;

    if (state == ST_LOAD) begin
      sel_k   = '0;
      sel_pi  = B_M;
      buf_src = buf_byp;
    end else begin
      sel_k   = k + ONE;
      sel_pi  = pi_k + A_M;  // power-of-two length: wrap is the mod
      buf_src = blk_buf;
    end
    u1 = buf_src[sel_k];
    u2 = buf_src[sel_pi];

`ifdef TURBO_TAIL_EN
    load_tail = (state == ST_TAIL) || ((state == ST_ENC) && (k == LAST_IDX));
    next_last = (state == ST_TAIL) && (tail_cnt == TAIL_LAST - 2'd1);
`else
    load_tail = 1'b0;
    next_last = (sel_k == LAST_IDX);
`endif
  end

  rsc_encoder u_rsc1 (
    .clk     (clk),
    .reset   (reset),
    .clear   (fire && out_last),
    .enable  (load),
    .tail    (load_tail),
    .u       (u1),
    .sys_bit (sys1),
    .parity  (p1)
  );

  rsc_encoder u_rsc2 (
    .clk     (clk),
    .reset   (reset),
    .clear   (fire && out_last),
    .enable  (load),
    .tail    (load_tail),
    .u       (u2),
    .sys_bit (unused_sys2),
    .parity  (p2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      blk_buf   <= '0;
      count     <= '0;
      k         <= '0;
      pi_k      <= '0;
      out_valid <= 1'b0;
      out_sys   <= 1'b0;
      out_p1    <= 1'b0;
      out_p2    <= 1'b0;
      out_last  <= 1'b0;
`ifdef TURBO_TAIL_EN
      tail_cnt  <= '0;
`endif
    end else begin
      if (accept) begin
        blk_buf[count] <= in_data;
        count          <= count + ONE;
      end
      if (last_in) begin
        state <= ST_ENC;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_sys   <= sys1;
        out_p1    <= p1;
        out_p2    <= p2;
        out_last  <= next_last;
        k         <= sel_k;
        pi_k      <= sel_pi;
      end
      if (fire) begin
        if (out_last) begin
          state     <= ST_LOAD;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          count     <= '0;
          k         <= '0;
          pi_k      <= '0;
`ifdef TURBO_TAIL_EN
        end else if ((state == ST_ENC) && (k == LAST_IDX)) begin
          state    <= ST_TAIL;
          tail_cnt <= '0;
        end else if (state == ST_TAIL) begin
          tail_cnt <= tail_cnt + 2'd1;
`endif
        end
      end
    end
  end

  assign in_ready = (state == ST_LOAD);
  assign busy     = !((state == ST_LOAD) && (count == '0));

endmodule

// File: doc/turbo_block_encoder.md
TURBO_BLOCK_ENCODER -- requirements
Module: turbo_block_encoder

Interface
REQ-001 Parameter BLK_LEN, 16, information bits per block; power of two, 8..64.
REQ-002 Parameter INTLV_A, 5, interleaver multiplier; odd, less than BLK_LEN.
REQ-003 Parameter INTLV_B, 3, interleaver offset; less than BLK_LEN.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  in_data carries an information bit.
REQ-007 in_data  in  1  information bit.
REQ-008 in_ready  out  1  block accepts in_data this cycle.
REQ-009 out_valid  out  1  output symbol valid.
REQ-010 out_ready  in  1  downstream accepts the symbol.
REQ-011 out_sys, out_p1, out_p2  out  1 each  systematic, parity-1 and parity-2 bits.
REQ-012 out_last  out  1  final symbol of the block.
REQ-013 busy  out  1  high in any state other than LOAD with count 0.

Function
REQ-014 The FSM SHALL have states LOAD, ENC and TAIL; it SHALL leave reset in LOAD with count 0.
REQ-015 LOAD: in_ready=1; each in_valid cycle SHALL store in_data at buf[count] and increment count; on accepting bit BLK_LEN-1 it SHALL go to ENC with k=0 and both encoder states 000.
REQ-016 in_ready SHALL be 0 in ENC and TAIL; in_valid there SHALL be ignored.
REQ-017 Each RSC encoder with state s=[s1,s2,s3] and input u SHALL compute a=u^s2^s3 (feedback 1+D^2+D^3), parity=a^s1^s3 (1+D+D^3), next state [a,s1,s2].
REQ-018 Interleaver SHALL be pi(k)=(INTLV_A*k+INTLV_B) mod BLK_LEN, computed with modular counter arithmetic, not a ROM.
REQ-019 ENC symbol k SHALL be: out_sys=buf[k]; out_p1=encoder-1 parity for input buf[k]; out_p2=encoder-2 parity for input buf[pi(k)].
REQ-020 Outputs SHALL be registered; the first out_valid SHALL appear the cycle after the last input bit is accepted.
REQ-021 A symbol SHALL advance (k++, encoder states update) only when out_valid and out_ready are both 1; otherwise all outputs and state SHALL hold.
REQ-022 out_valid SHALL stay 1 from the first ENC symbol to the out_last handshake, with no gaps while out_ready=1.
REQ-023 After the out_last handshake the block SHALL return to LOAD with count 0 and in_ready=1 in the next cycle.

Reset
REQ-024 Reset SHALL set out_valid, out_sys, out_p1, out_p2, out_last, busy to 0, set in_ready to 1 on the first cycle after release, and clear count, k and both encoder states.
REQ-025 Reset mid-LOAD, mid-ENC or mid-TAIL SHALL discard the partial block; no further symbol from it SHALL be emitted.

Configuration
REQ-026 With TURBO_TAIL_EN defined, ENC SHALL be followed by TAIL: 3 symbols, each encoder driven with u=s2^s3 (a=0).
REQ-027 In TAIL, out_sys SHALL be encoder-1's tail input, out_p1 encoder-1 parity, out_p2 encoder-2 parity; out_last SHALL mark tail symbol 3; both encoders SHALL end in state 000.
REQ-028 Without TURBO_TAIL_EN, the TAIL state and its logic SHALL be absent; out_last SHALL mark ENC symbol BLK_LEN-1.

Structure
REQ-029 Package turbo_pkg SHALL hold the generator constants (G_FB=4'b1101, G_FF=4'b1011), the FSM state enum and the tail length constant 3.
REQ-030 The RSC step SHALL be a sub-module rsc_encoder (state register, enable, clear, tail-mode input), instantiated twice.

Verification
REQ-031 BLK_LEN=8, all-zero block, out_ready=1 -> 8 symbols (11 with TURBO_TAIL_EN), every bit 0, out_last on the final symbol.
REQ-032 BLK_LEN=8, A=5, B=3, block 1,0,0,0,0,0,0,0 -> out_sys 10000000; out_p1 11110010; out_p2 01111001.
REQ-033 Same block, out_ready toggled 1,0,0,1 repeatedly -> identical symbol sequence; outputs stable during stalls.
REQ-034 Reset asserted at ENC symbol 4 -> out_valid=0 next cycle, in_ready=1 after release, next block encodes from zero state.
REQ-035 Two back-to-back blocks, in_valid held high -> in_ready=0 throughout ENC/TAIL; the second block is accepted only after the first block's out_last.
REQ-036 TURBO_TAIL_EN, random 16-bit block -> both encoder states 000 after the 3 tail symbols.
